// File: rtl/bulk_in_packet_arbiter_if.sv
// AXIS bundle for the bulk IN arbiter: NUM_CHAN byte-wide sources on one side, one byte-wide sink on the other.
// "master" is the arbiter's view; "slave" is the environment (sources plus the bulk IN endpoint).
interface bulk_in_packet_arbiter_if #(
  parameter int NUM_CHAN = 2
);
  logic [NUM_CHAN-1:0]   s_axis_tvalid;
  logic [NUM_CHAN-1:0]   s_axis_tready;
  logic [8*NUM_CHAN-1:0] s_axis_tdata;
  logic [NUM_CHAN-1:0]   s_axis_tlast;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [7:0]            m_axis_tdata;
  logic                  m_axis_tlast;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/bulk_in_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing the bulk IN AXIS sink among NUM_CHAN sources,
// with an optional channel-ID header byte and forced splitting at MAX_PKT_LEN payload bytes.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no owner; pick next requester in round-robin order
// ST_HEADER | emitting {4'hA,1'b0,chan} header byte for the owner
// ST_DATA   | combinational pass-through of the owner's payload
module bulk_in_packet_arbiter #(
  parameter int NUM_CHAN    = 2,
  parameter int HEADER_EN   = 1,
  parameter int MAX_PKT_LEN = 512
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  bulk_in_packet_arbiter_if.master axis,
  output logic [NUM_CHAN-1:0]    grant_o,
  output logic                   busy_o,
  output logic [15:0]            pkt_count_o
);

  localparam int PW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [15:0] LAST_CNT = 16'(MAX_PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_t;

  localparam state_t FIRST_ST = (HEADER_EN != 0) ? ST_HEADER : ST_DATA;

  state_t        state_q, state_d;
  logic [PW-1:0] gnt_q, gnt_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   pkt_q, pkt_d;

  logic          sel_found;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] probe_idx;

  logic                m_tvalid;
  logic [7:0]          m_tdata;
  logic                m_tlast;
  logic [NUM_CHAN-1:0] s_tready;

  // Walk downward so the requester closest to rr_q (smallest offset) is the last one written.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = rr_q;
    probe_idx = '0;
    for (int k = NUM_CHAN - 1; k >= 0; k--) begin
      probe_idx = PW'((int'(rr_q) + k) % NUM_CHAN);
      if (axis.s_axis_tvalid[probe_idx]) begin
        sel_found = 1'b1;
        sel_idx   = probe_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    pkt_d    = pkt_q;
    m_tvalid = 1'b0;
    m_tdata  = 8'h00;
    m_tlast  = 1'b0;
    s_tready = '0;
    grant_o  = '0;
    busy_o   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          gnt_d   = sel_idx;
          cnt_d   = 16'd0;
          state_d = FIRST_ST;
        end
      end

      ST_HEADER: begin
        busy_o         = 1'b1;
        grant_o[gnt_q] = 1'b1;
        m_tvalid       = 1'b1;
        m_tdata        = {4'hA, 1'b0, 3'(gnt_q)};
        if (axis.m_axis_tready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        busy_o          = 1'b1;
        grant_o[gnt_q]  = 1'b1;
        m_tvalid        = axis.s_axis_tvalid[gnt_q];
        m_tdata         = axis.s_axis_tdata[{gnt_q, 3'b000} +: 8];
        m_tlast         = axis.s_axis_tlast[gnt_q] | (cnt_q == LAST_CNT);
        s_tready[gnt_q] = axis.m_axis_tready;
        if (m_tvalid && axis.m_axis_tready) begin
          cnt_d = cnt_q + 16'd1;
          if (m_tlast) begin
            state_d = ST_IDLE;
            rr_d    = (int'(gnt_q) == NUM_CHAN - 1) ? '0 : gnt_q + PW'(1);
            pkt_d   = pkt_q + 16'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= 16'd0;
      pkt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
    end
  end

  assign axis.m_axis_tvalid = m_tvalid;
  assign axis.m_axis_tdata  = m_tdata;
  assign axis.m_axis_tlast  = m_tlast;
  assign axis.s_axis_tready = s_tready;
  assign pkt_count_o        = pkt_q;

endmodule

// File: tb/tb_bulk_in_packet_arbiter.sv
// Scoreboard bench for bulk_in_packet_arbiter: two queued byte sources, expected output beats
// {grant, tlast, tdata} queued up front and popped on every accepted output beat.
module tb_bulk_in_packet_arbiter;
  localparam int NCH = 2;

  logic            sys_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NCH-1:0]  grant_o;
  logic            busy_o;
  logic [15:0]     pkt_count_o;

  bulk_in_packet_arbiter_if #(.NUM_CHAN(NCH)) axis_if ();

  bulk_in_packet_arbiter #(
    .NUM_CHAN   (NCH),
    .HEADER_EN  (1),
    .MAX_PKT_LEN(4)
  ) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .axis       (axis_if),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .pkt_count_o(pkt_count_o)
  );

  always #5 sys_clk = ~sys_clk;

  logic [8:0]  src_q[NCH][$];
  logic [10:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          rdy_toggle = 1'b0;
  bit          rdy_phase  = 1'b0;
  bit          prev_last_acc = 1'b0;
  bit          prev_stall    = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        last_m_tvalid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input bit last, input logic [7:0] d);
    logic [NCH-1:0] g;
    g = NCH'(1) << ch;
    exp_q.push_back({g, last, d});
  endtask

  task automatic src_pkt(input int ch, input logic [7:0] first, input logic [7:0] step, input int n);
    for (int i = 0; i < n; i++)
      src_q[ch].push_back({(i == n - 1), 8'(first + step * 8'(i))});
  endtask

  task automatic exp_pkt(input int ch, input logic [7:0] first, input logic [7:0] step, input int n);
    push_exp(ch, 1'b0, 8'hA0 | 8'(ch));
    for (int i = 0; i < n; i++)
      push_exp(ch, (i == n - 1), 8'(first + step * 8'(i)));
  endtask

  task automatic tick();
    bit             m_acc;
    bit             stall;
    logic [NCH-1:0] s_acc;
    logic [10:0]    e;
    for (int c = 0; c < NCH; c++) begin
      axis_if.s_axis_tvalid[c] = (src_q[c].size() != 0);
      if (src_q[c].size() != 0) begin
        axis_if.s_axis_tdata[8*c +: 8] = src_q[c][0][7:0];
        axis_if.s_axis_tlast[c]        = src_q[c][0][8];
      end else begin
        axis_if.s_axis_tdata[8*c +: 8] = 8'h00;
        axis_if.s_axis_tlast[c]        = 1'b0;
      end
    end
    axis_if.m_axis_tready = rdy_toggle ? rdy_phase : 1'b1;
    #1;
    last_m_tvalid = axis_if.m_axis_tvalid;
    m_acc = reset_n && axis_if.m_axis_tvalid && axis_if.m_axis_tready;
    s_acc = axis_if.s_axis_tvalid & axis_if.s_axis_tready & {NCH{reset_n}};
    if (reset_n) begin
      if (prev_last_acc) begin
        chk("bubble_busy", busy_o, 0);
        chk("bubble_tvalid", axis_if.m_axis_tvalid, 0);
      end
      if (prev_stall) begin
        chk("hold_tvalid", axis_if.m_axis_tvalid, 1);
        chk("hold_tdata", axis_if.m_axis_tdata, prev_data);
      end
      if (m_acc) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", axis_if.m_axis_tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {grant_o, axis_if.m_axis_tlast, axis_if.m_axis_tdata}, e);
        end
      end
    end
    stall     = reset_n && axis_if.m_axis_tvalid && !axis_if.m_axis_tready;
    prev_data = axis_if.m_axis_tdata;
    @(posedge sys_clk);
    for (int c = 0; c < NCH; c++)
      if (s_acc[c]) void'(src_q[c].pop_front());
    prev_last_acc = m_acc && axis_if.m_axis_tlast;
    prev_stall    = stall;
    rdy_phase     = ~rdy_phase;
    @(negedge sys_clk);
  endtask

  task automatic run(input int budget, input bit wait_src);
    int  cyc;
    bit  busy_src;
    cyc = 0;
    busy_src = wait_src && (src_q[0].size() != 0 || src_q[1].size() != 0);
    while ((exp_q.size() != 0 || busy_src) && cyc < budget) begin
      tick();
      cyc++;
      busy_src = wait_src && (src_q[0].size() != 0 || src_q[1].size() != 0);
    end
    chk("drain", exp_q.size(), 0);
    if (wait_src) begin
      tick();
      tick();
    end
  endtask

  task automatic do_reset();
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    exp_q.delete();
    reset_n = 1'b0;
    tick();
    reset_n       = 1'b1;
    prev_last_acc = 1'b0;
    prev_stall    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    axis_if.s_axis_tvalid = '0;
    axis_if.s_axis_tdata  = '0;
    axis_if.s_axis_tlast  = '0;
    axis_if.m_axis_tready = 1'b1;
    @(negedge sys_clk);

    // reset held with every source requesting
    src_pkt(0, 8'hEE, 8'h00, 1);
    src_pkt(1, 8'hEF, 8'h00, 1);
    reset_n = 1'b0;
    repeat (3) tick();
    #1;
    chk("rst_m_tvalid", axis_if.m_axis_tvalid, 0);
    chk("rst_s_tready", axis_if.s_axis_tready, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_pkt_count", pkt_count_o, 0);
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    axis_if.s_axis_tvalid = '0;
    reset_n = 1'b1;
    @(negedge sys_clk);

    // single source on ch1, including first-beat latency
    src_pkt(1, 8'h11, 8'h11, 4);
    exp_pkt(1, 8'h11, 8'h11, 4);
    tick();
    chk("lat_idle", last_m_tvalid, 0);
    tick();
    chk("lat_first", last_m_tvalid, 1);
    run(50, 1);
    chk("pkt_single", pkt_count_o, 1);

    // fairness: both channels continuously requesting
    do_reset();
    src_pkt(0, 8'h01, 8'h01, 3);
    src_pkt(0, 8'h04, 8'h01, 3);
    src_pkt(1, 8'h81, 8'h01, 3);
    src_pkt(1, 8'h84, 8'h01, 3);
    exp_pkt(0, 8'h01, 8'h01, 3);
    exp_pkt(1, 8'h81, 8'h01, 3);
    exp_pkt(0, 8'h04, 8'h01, 3);
    exp_pkt(1, 8'h84, 8'h01, 3);
    run(100, 1);
    chk("pkt_fair", pkt_count_o, 4);

    // toggling backpressure; ch0 5-byte packet is split at 4 and its tail waits behind ch1
    do_reset();
    rdy_toggle = 1'b1;
    src_pkt(0, 8'h20, 8'h01, 5);
    src_pkt(1, 8'h30, 8'h01, 3);
    exp_pkt(0, 8'h20, 8'h01, 4);
    exp_pkt(1, 8'h30, 8'h01, 3);
    exp_pkt(0, 8'h24, 8'h01, 1);
    run(200, 1);
    chk("pkt_bp", pkt_count_o, 3);
    rdy_toggle = 1'b0;

    // forced split of a 6-byte packet
    do_reset();
    src_pkt(0, 8'h40, 8'h01, 6);
    exp_pkt(0, 8'h40, 8'h01, 4);
    exp_pkt(0, 8'h44, 8'h01, 2);
    run(100, 1);
    chk("pkt_split", pkt_count_o, 2);

    // reset after 2 of 5 bytes, then resend the whole packet
    do_reset();
    src_pkt(0, 8'h50, 8'h01, 5);
    push_exp(0, 1'b0, 8'hA0);
    push_exp(0, 1'b0, 8'h50);
    push_exp(0, 1'b0, 8'h51);
    run(50, 0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_rst_grant", grant_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_pkt", pkt_count_o, 0);
    src_q[0].delete();
    src_pkt(0, 8'h50, 8'h01, 5);
    exp_pkt(0, 8'h50, 8'h01, 4);
    exp_pkt(0, 8'h54, 8'h01, 1);
    run(100, 1);
    chk("pkt_resend", pkt_count_o, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
